led_driver_rx: RTL and testbench

Receive-side decoder for the serial LED-driver link (SDI/DCLK/LE) that the matrix output block drives. It oversamples the three link pins in the system clock domain, shifts in 16-bit words, counts DCLK edges taken while LE is high, and decodes that latch length into a command. Decoded commands become gray-data writes, config-register updates, a VSYNC pulse and an outputs-enabled flag. The block serves as the bench-side model for the matrix output block and as a front end for an FPGA-emulated driver chip.

---
 rtl/led_driver_rx.sv | 213 +++++++++++++++++++++
 tb/tb_led_driver_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_driver_rx.sv
// Receive-side decoder for the SDI/DCLK/LE LED-driver link: oversamples the pins,
// shifts in 16-bit words and turns the LE-high DCLK count into commands.
module led_driver_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdi,
  input  logic        dclk,
  input  logic        le,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] cfg1,
  output logic [15:0] cfg2,
  output logic        outputs_en,
  output logic        vsync,
  output logic        cmd_valid,
  output logic [4:0]  cmd_len,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DECODE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sdi_sync_q, dclk_sync_q, le_sync_q;
  logic                   dclk_prev_q, le_prev_q;
  logic                   sdi_s, dclk_s, le_s, dclk_rise, le_fall;

  logic [15:0] shift_q, shift_d;
  logic [4:0]  le_cnt_q, le_cnt_d;
  logic [3:0]  ch_q, ch_d;
  logic [4:0]  row_q, row_d;
  logic        pre_armed_q, pre_armed_d;
  logic [15:0] cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic        outputs_en_q, outputs_en_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        vsync_q, vsync_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [4:0]  cmd_len_q, cmd_len_d;
  logic        cmd_err_q, cmd_err_d;

  // Equal-depth chains keep sdi/le aligned with the dclk edge that samples them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_sync_q  <= '0;
      dclk_sync_q <= '0;
      le_sync_q   <= '0;
      dclk_prev_q <= 1'b0;
      le_prev_q   <= 1'b0;
    end else begin
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], dclk};
      le_sync_q   <= {le_sync_q[SYNC_STAGES-2:0], le};
      dclk_prev_q <= dclk_s;
      le_prev_q   <= le_s;
    end
  end

  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign dclk_s    = dclk_sync_q[SYNC_STAGES-1];
  assign le_s      = le_sync_q[SYNC_STAGES-1];
  assign dclk_rise = dclk_s & ~dclk_prev_q;
  assign le_fall   = ~le_s & le_prev_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    le_cnt_d     = le_cnt_q;
    ch_d         = ch_q;
    row_d        = row_q;
    pre_armed_d  = pre_armed_q;
    cfg1_d       = cfg1_q;
    cfg2_d       = cfg2_q;
    outputs_en_d = outputs_en_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    vsync_d      = 1'b0;
    cmd_valid_d  = 1'b0;
    cmd_len_d    = cmd_len_q;
    cmd_err_d    = 1'b0;

    if (dclk_rise) begin
      shift_d = {shift_q[14:0], sdi_s};
      if (le_s && (le_cnt_q != 5'd31)) begin
        le_cnt_d = le_cnt_q + 5'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (dclk_rise) state_d = SHIFT;
      end
      SHIFT: begin
        if (le_s) state_d = LATCH;
      end
      LATCH: begin
        if (le_fall) state_d = DECODE;
      end
      DECODE: begin
        state_d     = SHIFT;
        le_cnt_d    = 5'd0;
        cmd_valid_d = 1'b1;
        cmd_len_d   = le_cnt_q;
        case (le_cnt_q)
          5'd1: begin
            wr_en_d     = 1'b1;
            wr_data_d   = shift_q;
            wr_addr_d   = {row_q, ch_q};
            ch_d        = ch_q + 4'd1;
            pre_armed_d = 1'b0;
            // A row index beyond a freshly shrunk scan count also folds back to 0.
            if (ch_q == 4'd15) begin
              row_d = (row_q >= cfg1_q[12:8]) ? 5'd0 : row_q + 5'd1;
            end
          end
          5'd3: begin
            vsync_d     = 1'b1;
            ch_d        = 4'd0;
            row_d       = 5'd0;
            pre_armed_d = 1'b0;
          end
          5'd4: begin
            if (pre_armed_q) begin
              cfg1_d      = shift_q;
              pre_armed_d = 1'b0;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          5'd6: begin
            if (pre_armed_q) begin
              cfg2_d      = shift_q;
              pre_armed_d = 1'b0;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          5'd12: begin
            outputs_en_d = 1'b1;
            pre_armed_d  = 1'b0;
          end
          5'd14: begin
            pre_armed_d = 1'b1;
          end
          default: begin
            cmd_err_d = 1'b1;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      le_cnt_q     <= '0;
      ch_q         <= '0;
      row_q        <= '0;
      pre_armed_q  <= 1'b0;
      cfg1_q       <= '0;
      cfg2_q       <= '0;
      outputs_en_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      vsync_q      <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_len_q    <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      le_cnt_q     <= le_cnt_d;
      ch_q         <= ch_d;
      row_q        <= row_d;
      pre_armed_q  <= pre_armed_d;
      cfg1_q       <= cfg1_d;
      cfg2_q       <= cfg2_d;
      outputs_en_q <= outputs_en_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      vsync_q      <= vsync_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_len_q    <= cmd_len_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cfg1       = cfg1_q;
  assign cfg2       = cfg2_q;
  assign outputs_en = outputs_en_q;
  assign vsync      = vsync_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_len    = cmd_len_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_led_driver_rx.sv
// Bench for led_driver_rx: drives link words, predicts each decoded command from
// the command table and compares every cycle after the synchronizer latency.
module tb_led_driver_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n, sdi, dclk, le;
  logic        wr_en, outputs_en, vsync, cmd_valid, cmd_err;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data, cfg1, cfg2;
  logic [4:0]  cmd_len;

  led_driver_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .dclk(dclk), .le(le),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg1(cfg1), .cfg2(cfg2), .outputs_en(outputs_en), .vsync(vsync),
    .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [8:0]  addr;
    logic [15:0] data;
    bit          vs;
    bit          err;
    logic [4:0]  len;
    logic [15:0] c1;
    logic [15:0] c2;
    bit          oe;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (driver side)
  int          m_row, m_ch;
  bit          m_armed, m_oe;
  logic [15:0] m_cfg1, m_cfg2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_ch = 0; m_armed = 0; m_oe = 0; m_cfg1 = '0; m_cfg2 = '0;
  endtask

  task automatic send_bit(input logic b, input logic l);
    sdi = b; le = l;
    repeat (2) @(negedge clk);
    dclk = 1'b1;
    repeat (2) @(negedge clk);
    dclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Sends a word with LE held high over the last n DCLK rises, predicts the result.
  task automatic do_cmd(input logic [15:0] w, input int n, output logic [8:0] waddr);
    exp_t e;
    int   total, len, lines;
    logic b;
    total = (n > 16) ? n : 16;
    for (int k = 0; k < total; k++) begin
      int bi;
      bi = total - 1 - k;
      b = (bi < 16) ? w[bi] : 1'b0;
      send_bit(b, k >= total - n);
    end
    le = 1'b0;
    len = (n > 31) ? 31 : n;
    e.cyc = cyc + SYNC + 2;
    e.wr = 0; e.vs = 0; e.err = 0; e.addr = '0; e.data = w; e.len = 5'(len);
    case (len)
      1: begin
        e.wr = 1;
        e.addr = 9'(m_row * 16 + m_ch);
        m_armed = 0;
        m_ch = m_ch + 1;
        if (m_ch == 16) begin
          m_ch = 0;
          lines = int'(m_cfg1[12:8]) + 1;
          m_row = (m_row + 1 >= lines) ? 0 : m_row + 1;
        end
      end
      3: begin e.vs = 1; m_row = 0; m_ch = 0; m_armed = 0; end
      4: if (m_armed) begin m_cfg1 = w; m_armed = 0; end else e.err = 1;
      6: if (m_armed) begin m_cfg2 = w; m_armed = 0; end else e.err = 1;
      12: begin m_oe = 1; m_armed = 0; end
      14: m_armed = 1;
      default: e.err = 1;
    endcase
    e.c1 = m_cfg1; e.c2 = m_cfg2; e.oe = m_oe;
    exp_q.push_back(e);
    waddr = e.addr;
    repeat (8) @(negedge clk);
  endtask

  // Compare process: every cycle, just after the active edge.
  initial begin
    exp_t        e;
    logic [15:0] cur_c1, cur_c2;
    logic        cur_oe;
    cur_c1 = '0; cur_c2 = '0; cur_oe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_strobes", {wr_en, vsync, cmd_valid, cmd_err, outputs_en, cmd_len}, 0);
        check("reset_cfg", {cfg1, cfg2}, 0);
        cur_c1 = '0; cur_c2 = '0; cur_oe = 1'b0;
      end else begin
        if (cmd_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_cmd_valid", cmd_valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("cmd_latency", cyc, e.cyc);
            check("wr_en", wr_en, e.wr);
            check("vsync", vsync, e.vs);
            check("cmd_err", cmd_err, e.err);
            check("cmd_len", cmd_len, e.len);
            if (e.wr) begin
              check("wr_addr", wr_addr, e.addr);
              check("wr_data", wr_data, e.data);
            end
            cur_c1 = e.c1; cur_c2 = e.c2; cur_oe = e.oe;
          end
        end else begin
          check("idle_strobes", {wr_en, vsync, cmd_err}, 0);
          if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            check("missing_cmd", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
          end
        end
        check("cfg1", cfg1, cur_c1);
        check("cfg2", cfg2, cur_c2);
        check("outputs_en", outputs_en, cur_oe);
      end
    end
  end

  initial begin
    logic [8:0] a;
    int         r;
    rst_n = 1'b0; sdi = 1'b0; dclk = 1'b0; le = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_cmd(16'h0000, 14, a);
    do_cmd(16'h0350, 4, a);
    check("cfg1_literal", cfg1, 16'h0350);
    check("cfg1_len_literal", cmd_len, 4);

    do_cmd(16'hFFFF, 6, a);
    check("cfg2_unarmed_literal", cfg2, 16'h0000);
    check("cfg2_len_literal", cmd_len, 6);

    for (int i = 0; i < 65; i++) begin
      do_cmd(16'(i), 1, a);
      check("frame_addr", a, i % 64);
    end
    for (int i = 0; i < 36; i++) do_cmd(16'($urandom), 1, a);
    check("model_row_literal", m_row, 2);
    check("model_ch_literal", m_ch, 5);
    do_cmd(16'h0000, 3, a);
    do_cmd(16'h1234, 1, a);
    check("post_vsync_addr", a, 9'h000);

    do_cmd(16'h0000, 12, a);
    check("oe_literal", outputs_en, 1);
    do_cmd(16'h0000, 7, a);
    check("len7_literal", cmd_len, 7);
    check("oe_kept_literal", outputs_en, 1);

    do_cmd(16'hBEEF, 33, a);
    check("len_saturated_literal", cmd_len, 31);

    // Reset in the middle of a latch: 9 bits, LE high over the last two rises.
    for (int k = 0; k < 9; k++) send_bit(1'($urandom), k >= 7);
    le = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    le = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_cmd(16'hA5A5, 1, a);
    check("post_reset_addr", a, 9'h000);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: do_cmd(16'($urandom), 1, a);
        5: do_cmd(16'($urandom), 3, a);
        6: begin
          if ($urandom_range(0, 3) != 0) do_cmd(16'h0000, 14, a);
          do_cmd(16'($urandom), 4, a);
        end
        7: begin
          if ($urandom_range(0, 3) != 0) do_cmd(16'h0000, 14, a);
          do_cmd(16'($urandom), 6, a);
        end
        8: do_cmd(16'($urandom), 12, a);
        default: do_cmd(16'($urandom), $urandom_range(1, 33), a);
      endcase
    end

    for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
